// File: rtl/chunk_loaded_addsub.sv
// Pushbutton-loaded bit-serial adder/subtractor. Operands are entered CHUNK bits
// per press and a GO press runs a WIDTH-cycle ripple through one full-adder stage.
module chunk_loaded_addsub #(
   parameter  int WIDTH  = 7,
   parameter  int CHUNK  = 4,
   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
   localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PB_A,
   input  logic             PB_B,
   input  logic             PB_GO,
   input  logic             MODE,
   input  logic [CHUNK-1:0] Y,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             valid,
   output logic             busy,
   output logic [PTRW-1:0]  ptr_a,
   output logic [PTRW-1:0]  ptr_b
);

   localparam int CNTW = $clog2(WIDTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic              prev_a, prev_b, prev_go;
   logic [WIDTH-1:0]  op_a, op_b;
   logic [WIDTH-1:0]  sa, sb, res;
   logic              c;
   logic [CNTW-1:0]   cnt;

   logic              ev_a, ev_b, ev_go;
   logic              bit_out, c_next;

   // Writes one chunk; bit positions past WIDTH-1 simply have no target.
   function automatic logic [WIDTH-1:0] load_chunk(input logic [WIDTH-1:0] cur,
                                                   input logic [PTRW-1:0]  ptr,
                                                   input logic [CHUNK-1:0] y);
      logic [WIDTH-1:0] r;
      r = cur;
      for (int i = 0; i < WIDTH; i++) begin
         if (i / CHUNK == int'(ptr)) r[i] = y[i % CHUNK];
      end
      return r;
   endfunction

   function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] ptr);
      return (ptr == PTRW'(NCHUNK - 1)) ? '0 : ptr + PTRW'(1);
   endfunction

   always_comb begin
      ev_a    = PB_A  & ~prev_a;
      ev_b    = PB_B  & ~prev_b;
      ev_go   = PB_GO & ~prev_go;
      bit_out = sa[0] ^ sb[0] ^ c;
      c_next  = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         prev_a   <= 1'b1;
         prev_b   <= 1'b1;
         prev_go  <= 1'b1;
         op_a     <= '0;
         op_b     <= '0;
         sa       <= '0;
         sb       <= '0;
         res      <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         ptr_a    <= '0;
         ptr_b    <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         valid    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         prev_a  <= PB_A;
         prev_b  <= PB_B;
         prev_go <= PB_GO;
         valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (ev_a) begin
                  op_a  <= load_chunk(op_a, ptr_a, Y);
                  ptr_a <= next_ptr(ptr_a);
               end
               if (ev_b) begin
                  op_b  <= load_chunk(op_b, ptr_b, Y);
                  ptr_b <= next_ptr(ptr_b);
               end
               // NOTE: non-blocking updates mean a load in the GO cycle lands after the
               // snapshot below reads op_a/op_b, so the snapshot sees the older operands.
               if (ev_go) begin
                  sa    <= op_a;
                  sb    <= MODE ? ~op_b : op_b;
                  c     <= MODE;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               res <= {bit_out, res[WIDTH-1:1]};
               c   <= c_next;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + CNTW'(1);
               // On the MSB stage, c is the carry in and c_next the carry out.
               if (cnt == CNTW'(WIDTH - 1)) begin
                  sum      <= {bit_out, res[WIDTH-1:1]};
                  carry    <= c_next;
                  overflow <= c ^ c_next;
                  valid    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_loaded_addsub.sv
// Scoreboard bench for chunk_loaded_addsub: expected results are queued at GO and
// a negedge monitor compares them whenever valid is seen.
module tb_chunk_loaded_addsub;

   localparam int W  = 7;
   localparam int C  = 4;
   localparam int NC = (W + C - 1) / C;
   localparam int PW = (NC > 1) ? $clog2(NC) : 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pb_a = 1'b0, pb_b = 1'b0, pb_go = 1'b0, mode = 1'b0;
   logic [C-1:0]  y = '0;
   logic [W-1:0]  sum;
   logic          carry, overflow, valid, busy;
   logic [PW-1:0] ptr_a, ptr_b;

   chunk_loaded_addsub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .PB_A(pb_a), .PB_B(pb_b), .PB_GO(pb_go), .MODE(mode),
      .Y(y), .sum(sum), .carry(carry), .overflow(overflow), .valid(valid),
      .busy(busy), .ptr_a(ptr_a), .ptr_b(ptr_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int carry;
      int ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0, n_pass = 0;
   int   valid_seen = 0, ops_issued = 0;
   logic valid_d = 1'b0;

   // Operand model: plain integers plus chunk pointers.
   int m_a = 0, m_b = 0, m_pa = 0, m_pb = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t ref_op(input int a, input int b, input bit md);
      exp_t e;
      int   full, r, s_a, s_b, s_r;
      full  = 1 << W;
      r     = md ? a - b : a + b;
      e.sum = ((r % full) + full) % full;
      e.carry = md ? int'(a >= b) : int'(a + b >= full);
      s_a   = (a >= full / 2) ? a - full : a;
      s_b   = (b >= full / 2) ? b - full : b;
      s_r   = md ? s_a - s_b : s_a + s_b;
      e.ovf = int'(s_r > full / 2 - 1 || s_r < -(full / 2));
      return e;
   endfunction

   function automatic int chunk_write(input int cur, input int ptr, input int yv);
      int mask;
      mask = (((1 << C) - 1) << (ptr * C)) & ((1 << W) - 1);
      return (cur & ~mask) | ((yv << (ptr * C)) & mask);
   endfunction

   always @(negedge clk) begin
      if (valid) begin
         valid_seen++;
         check("valid_one_cycle", int'(valid_d), 0);
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got valid=1, expected no pending operation");
         end else begin
            mon_e = sb_q.pop_front();
            check("sum", int'(sum), mon_e.sum);
            check("carry", int'(carry), mon_e.carry);
            check("overflow", int'(overflow), mon_e.ovf);
         end
      end
      valid_d = valid;
   end

   task automatic model_reset();
      m_a = 0; m_b = 0; m_pa = 0; m_pb = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sum"}, int'(sum), 0);
      check({tag, "_carry"}, int'(carry), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_ptr_a"}, int'(ptr_a), 0);
      check({tag, "_ptr_b"}, int'(ptr_b), 0);
   endtask

   task automatic press(input bit is_b, input int yv);
      y = C'(yv);
      if (is_b) pb_b = 1'b1; else pb_a = 1'b1;
      tick();
      pb_a = 1'b0;
      pb_b = 1'b0;
      if (is_b) begin
         m_b  = chunk_write(m_b, m_pb, yv);
         m_pb = (m_pb + 1) % NC;
         check("ptr_b", int'(ptr_b), m_pb);
      end else begin
         m_a  = chunk_write(m_a, m_pa, yv);
         m_pa = (m_pa + 1) % NC;
         check("ptr_a", int'(ptr_a), m_pa);
      end
      tick();
   endtask

   // Loads a full operand starting from chunk 0.
   task automatic load_val(input bit is_b, input int val);
      for (int k = 0; k < NC; k++) press(is_b, (val >> (k * C)) & ((1 << C) - 1));
   endtask

   task automatic run_op(input bit md, input bit poke);
      sb_q.push_back(ref_op(m_a, m_b, md));
      ops_issued++;
      mode  = md;
      pb_go = 1'b1;
      tick();
      pb_go = 1'b0;
      for (int i = 1; i <= W; i++) begin
         check("busy_during_op", int'(busy), 1);
         check("valid_during_op", int'(valid), 0);
         if (poke && i == 2) begin
            y    = '1;
            pb_a = 1'b1;
         end
         if (poke && i == 4) pb_a = 1'b0;
         tick();
      end
      check("busy_at_done", int'(busy), 0);
      check("valid_at_done", int'(valid), 1);
      if (poke) check("ptr_a_after_ignored_press", int'(ptr_a), m_pa);
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1);
   end

   initial begin
      int cnt;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      model_reset();
      check_all_zero("reset");

      // Basic add: A=0x25, B=0x13
      press(0, 5); press(0, 2);
      press(1, 3); press(1, 1);
      run_op(0, 0);

      // Carry-out and signed overflow corners
      load_val(0, 'h7F); load_val(1, 'h01); run_op(0, 0);
      load_val(0, 'h3F); load_val(1, 'h01); run_op(0, 0);

      // Subtract with and without borrow
      load_val(0, 'h10); load_val(1, 'h20); run_op(1, 0);
      load_val(0, 'h20); load_val(1, 'h10); run_op(1, 0);

      // Pointer wrap and last-chunk truncation, observed through A+0
      press(0, 1); press(0, 'hA); press(0, 3);
      load_val(1, 0);
      run_op(0, 0);
      press(0, 2);

      // PB_A press during busy is dropped; the follow-up op re-checks A
      load_val(0, 'h55); load_val(1, 'h0A);
      run_op(0, 1);
      run_op(1, 0);

      // GO held for 20 cycles gives exactly one operation
      load_val(0, 'h11); load_val(1, 'h22);
      sb_q.push_back(ref_op(m_a, m_b, 1'b0));
      ops_issued++;
      mode  = 1'b0;
      pb_go = 1'b1;
      cnt   = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valid) cnt++;
      end
      pb_go = 1'b0;
      check("held_go_valid_count", cnt, 1);
      check("held_go_busy_after", int'(busy), 0);
      tick();

      // GO held high through reset release starts nothing
      pb_go = 1'b1;
      rst   = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (busy || valid) cnt++;
      end
      check("go_through_reset_activity", cnt, 0);
      pb_go = 1'b0;
      tick();

      // Reset in cycle T+3 of an operation aborts it
      load_val(0, 'h2B); load_val(1, 'h19); run_op(0, 0);
      load_val(0, 'h33); load_val(1, 'h44); press(0, 7);
      mode  = 1'b1;
      pb_go = 1'b1;
      tick();
      pb_go = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_all_zero("abort");
      rst = 1'b0;
      model_reset();
      cnt = 0;
      for (int i = 0; i < W + 3; i++) begin
         tick();
         if (valid || busy) cnt++;
      end
      check("abort_no_activity", cnt, 0);
      load_val(0, 'h0C); load_val(1, 'h35); run_op(1, 0);

      // Randomised loads and operations
      for (int n = 0; n < 40; n++) begin
         int na, nb;
         na = $urandom_range(0, 3);
         nb = $urandom_range(0, 3);
         for (int k = 0; k < na; k++) press(0, $urandom_range(0, (1 << C) - 1));
         for (int k = 0; k < nb; k++) press(1, $urandom_range(0, (1 << C) - 1));
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end

      tick();
      tick();
      check("pending_ops", sb_q.size(), 0);
      check("valid_count", valid_seen, ops_issued);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/chunk_loaded_addsub.md
# chunk_loaded_addsub

Parametrised pushbutton-operated adder/subtractor for the lab board datapath. Operands are entered CHUNK bits at a time from the switch bus Y, each chunk committed by a pushbutton with an auto-incrementing chunk pointer. A GO button starts a bit-serial add or subtract that takes WIDTH cycles. The block registers sum, carry-out and signed-overflow, and pulses valid when they are ready.

## Interface
- WIDTH, 7: operand/result width in bits (>= 2).
- CHUNK, 4: bits loaded per button press (1..WIDTH).
- Derived: NCHUNK = ceil(WIDTH/CHUNK); PTRW = max(1, clog2(NCHUNK)).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- PB_A  in  1  debounced level; its rising edge loads the next chunk of A.
- PB_B  in  1  debounced level; its rising edge loads the next chunk of B.
- PB_GO  in  1  debounced level; its rising edge starts computation.
- MODE  in  1  0 = A+B, 1 = A−B; sampled on the GO event.
- Y  in  CHUNK  chunk data.
- sum  out  WIDTH  registered result.
- carry  out  1  final carry-out. In subtract mode, 1 means no borrow.
- overflow  out  1  two's-complement overflow of the result.
- valid  out  1  one-cycle pulse when the result updates.
- busy  out  1  high while computing.
- ptr_a  out  PTRW  index of the next A chunk to be written.
- ptr_b  out  PTRW  index of the next B chunk to be written.

## Operation
- **Edge detect:** each PB input has a previous-level register. Event = PB & ~prev.
  - prev registers reset to 1, so a button held through reset generates no event until it is released and pressed again.
  - A held button generates exactly one event.
- **Chunk load:** a PB_A event in IDLE writes Y into A bits [ptr_a*CHUNK +: CHUNK].
  - Bits beyond WIDTH-1 are discarded. For the last chunk only Y[(WIDTH − (NCHUNK−1)*CHUNK)−1:0] is used.
  - ptr_a then increments and wraps to 0 after NCHUNK−1.
  - PB_B and ptr_b behave identically for B.
  - Simultaneous A and B events are both accepted.
- **IDLE:** a GO event snapshots the following, then moves to BUSY with bit counter 0:
  - shift register SA ← A;
  - shift register SB ← (MODE ? ~B : B);
  - running carry c ← MODE;
  - MODE.
- **GO and load in the same cycle:**
  - The snapshot uses A/B as registered before that cycle.
  - The load still updates the A/B registers and its pointer, for use by the next operation.
- **BUSY:** each cycle computes one result bit from SA[0], SB[0] and c:
  - sum bit = SA[0]^SB[0]^c, shifted into the result shift register from the MSB side;
  - c ← majority(SA[0], SB[0], c);
  - SA and SB shift right; the counter increments.
  - The carry into the MSB stage is kept for the overflow computation.
- **Completion:** after the WIDTH-th bit:
  - sum ← result shift register;
  - carry ← c;
  - overflow ← (carry into MSB) XOR (carry out of MSB);
  - valid pulses; state returns to IDLE.
- **While BUSY:** PB_A, PB_B and PB_GO events are ignored and dropped, not queued. The pointers do not move. The prev registers still track the inputs.
- **Result hold:** sum, carry and overflow hold their values until the next completion.
- **Reset:**
  - sum, carry, overflow, valid, busy, ptr_a, ptr_b, A, B, SA, SB, counter: all 0.
  - State: IDLE.
  - prev registers: all 1.
  - A reset mid-BUSY aborts the operation with no valid pulse.

## Timing
- GO event in cycle T (PB_GO high, prev low):
  - busy = 1 in cycles T+1 .. T+WIDTH;
  - valid = 1 and new sum/carry/overflow in cycle T+WIDTH+1;
  - busy = 0 in cycle T+WIDTH+1.
- A new GO is accepted from cycle T+WIDTH+1 onward.
- Load event in cycle T: the operand register and pointer are updated in T+1.
- valid is never high for more than one consecutive cycle.

## Test plan
- **Basic add** (WIDTH=7, CHUNK=4): load A = 0x25 (Y=5 then 2) and B = 0x13 (Y=3 then 1), MODE=0, GO at T. Required: busy high T+1..T+7; valid at T+8; sum=0x38, carry=0, overflow=0; ptr_a=ptr_b=0 after the loads.
- **Carry and overflow:**
  - A=0x7F, B=0x01 add → sum=0x00, carry=1, overflow=0.
  - A=0x3F, B=0x01 add → sum=0x40, carry=0, overflow=1.
- **Subtract:** A=0x10, B=0x20, MODE=1 → sum=0x70, carry=0, overflow=0. Then A=0x20, B=0x10 → sum=0x10, carry=1.
- **Pointer wrap and truncation:** three PB_A presses with Y=1, 0xA, 3. Required: ptr_a sequence 0→1→0→1; A=0x23 (chunk1 Y=0xA kept only 0x2).
- **Ignored and edge events:**
  - PB_A press during busy → A and ptr_a unchanged.
  - PB_GO held high for 20 cycles → exactly one operation and one valid.
  - PB_GO high through reset release → no operation.
- **Reset mid-compute:** assert rst in cycle T+3 of an operation. Required: no valid pulse; all outputs 0 the next cycle; a fresh load and GO then gives correct results.
